mmio_button_port: RTL and testbench

//  Memory-mapped input responder on the CPU data bus; inbound counterpart of the display output path.

---
 rtl/mmio_button_port.sv | 151 +++++++++++++++
 tb/tb_mmio_button_port.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_button_port.sv
// rtl/mmio_button_port.sv - memory-mapped debounced button input port
//
// Purpose:
//   Synchronises and debounces raw board buttons, latches sticky press
//   events, counts presses and answers CPU loads/stores in a 4-word window
//   (LEVEL, EVENT, PRESS, IRQEN). Raises irq on any enabled pending event.
//
// Ports:
//   CLK        system clock
//   CLR        asynchronous active-high reset
//   btn_raw    raw asynchronous button pins, 1 = pressed
//   bus_en     one-cycle bus strobe; bus inputs sampled only when 1
//   bus_wr     1 = store, 0 = load
//   bus_addr   word address
//   bus_wdata  store data
//   bus_rdata  registered load data, bits 17:16 always 0
//   bus_hit    registered: previous strobe addressed this block
//   irq        |(EVENT & IRQEN)

module mmio_button_port #(
   parameter int          N_BTN      = 4,
   parameter logic [13:0] BASE_ADDR  = 14'h3FF0,
   parameter int          DEB_CYCLES = 1000000,
   parameter int          CNT_W      = 20
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic             bus_en,
   input  logic             bus_wr,
   input  logic [13:0]      bus_addr,
   input  logic [15:0]      bus_wdata,
   output logic [17:0]      bus_rdata,
   output logic             bus_hit,
   output logic             irq
);

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] stable;
   logic [N_BTN-1:0] stable_nxt;
   logic [CNT_W-1:0] cnt     [N_BTN];
   logic [CNT_W-1:0] cnt_nxt [N_BTN];
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] event_r;
   logic [N_BTN-1:0] irq_en;
   logic [15:0]      press_cnt;

   logic             hit;
   logic             acc;
   logic             st;
   logic             ld;
   logic [1:0]       off;
   logic [15:0]      rd_val;
   logic [N_BTN-1:0] w1c;
   logic             unused_wdata;

   function automatic logic [4:0] popcount(input logic [N_BTN-1:0] v);
      logic [4:0] s;
      s = '0;
      for (int i = 0; i < N_BTN; i++) begin
         s = s + 5'(v[i]);
      end
      return s;
   endfunction

   // Debounce: a level is accepted only after DEB_CYCLES consecutive
   // samples disagree with the current stable value; any agreeing sample
   // restarts the count.
   always_comb begin
      stable_nxt = stable;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_nxt[i] = '0;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
               stable_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // Press pulses coincide with the edge that updates stable, so LEVEL and
   // EVENT change on the same clock.
   assign press = stable_nxt & ~stable;

   assign hit = (bus_addr[13:2] == BASE_ADDR[13:2]);
   assign acc = bus_en && hit;
   assign st  = acc && bus_wr;
   assign ld  = acc && !bus_wr;
   assign off = bus_addr[1:0];

   always_comb begin
      rd_val = '0;
      case (off)
         2'd0:    rd_val = 16'(stable);
         2'd1:    rd_val = 16'(event_r);
         2'd2:    rd_val = press_cnt;
         default: rd_val = 16'(irq_en);
      endcase
   end

   assign w1c          = (st && off == 2'd1) ? bus_wdata[N_BTN-1:0] : '0;
   assign unused_wdata = ^bus_wdata;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         sync1     <= '0;
         sync2     <= '0;
         stable    <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt[i] <= '0;
         end
         event_r   <= '0;
         irq_en    <= '0;
         press_cnt <= '0;
         bus_rdata <= '0;
         bus_hit   <= 1'b0;
      end else begin
         sync1  <= btn_raw;
         sync2  <= sync1;
         stable <= stable_nxt;
         for (int i = 0; i < N_BTN; i++) begin
            cnt[i] <= cnt_nxt[i];
         end

         // Set after clear: a press arriving with a W1C of the same bit wins.
         event_r <= (event_r & ~w1c) | press;

         // A store to PRESS wins over (and discards) this cycle's presses.
         if (st && off == 2'd2) begin
            press_cnt <= '0;
         end else begin
            press_cnt <= press_cnt + 16'(popcount(press));
         end

         if (st && off == 2'd3) begin
            irq_en <= bus_wdata[N_BTN-1:0];
         end

         if (ld) begin
            bus_rdata <= {2'b00, rd_val};
         end
         bus_hit <= acc;
      end
   end

   assign irq = |(event_r & irq_en);

endmodule

// File: tb/tb_mmio_button_port.sv
// tb/tb_mmio_button_port.sv - randomized self-checking bench for mmio_button_port

module tb_mmio_button_port;

   localparam int          N    = 16;
   localparam int          DEB  = 4;
   localparam logic [13:0] BASE = 14'h3FF0;

   logic          CLK = 1'b0;
   logic          CLR = 1'b1;
   logic [N-1:0]  btn_raw = '0;
   logic          bus_en = 1'b0;
   logic          bus_wr = 1'b0;
   logic [13:0]   bus_addr = '0;
   logic [15:0]   bus_wdata = '0;
   logic [17:0]   bus_rdata;
   logic          bus_hit;
   logic          irq;

   int n_checks = 0;
   int n_errors = 0;

   mmio_button_port #(
      .N_BTN(N), .BASE_ADDR(BASE), .DEB_CYCLES(DEB), .CNT_W(20)
   ) dut (
      .CLK(CLK), .CLR(CLR), .btn_raw(btn_raw),
      .bus_en(bus_en), .bus_wr(bus_wr), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_hit(bus_hit), .irq(irq)
   );

   always #5 CLK = ~CLK;

   // Reference model: the level seen by the CPU flips once the last DEB
   // synchronised samples (raw delayed by two clocks) all disagree with it.
   logic [N-1:0] raw_q[$];
   logic [N-1:0] win[$];
   logic [N-1:0] m_level, m_event, m_irqen;
   logic [15:0]  m_press;
   logic [17:0]  m_rdata;
   logic         m_hit;

   function automatic void model_reset();
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      win.delete();
      m_level = '0; m_event = '0; m_irqen = '0;
      m_press = '0; m_rdata = '0; m_hit = 1'b0;
   endfunction

   function automatic logic m_irq();
      return |(m_event & m_irqen);
   endfunction

   function automatic void model_edge();
      logic [N-1:0] s, nl, rises, clr;
      logic         h, all_diff;
      logic [1:0]   o;
      logic [15:0]  rv;
      if (CLR) begin
         model_reset();
         return;
      end
      s = raw_q.pop_front();
      raw_q.push_back(btn_raw);
      win.push_back(s);
      if (win.size() > DEB) void'(win.pop_front());
      nl = m_level;
      if (win.size() == DEB) begin
         for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            foreach (win[k]) if (win[k][i] == m_level[i]) all_diff = 1'b0;
            if (all_diff) nl[i] = ~m_level[i];
         end
      end
      rises = nl & ~m_level;
      h = bus_en && (bus_addr[13:2] == BASE[13:2]);
      o = bus_addr[1:0];
      case (o)
         2'd0:    rv = m_level;
         2'd1:    rv = m_event;
         2'd2:    rv = m_press;
         default: rv = m_irqen;
      endcase
      if (h && !bus_wr) m_rdata = {2'b00, rv};
      m_hit = h;
      clr = (h && bus_wr && o == 2'd1) ? bus_wdata : '0;
      m_event = (m_event & ~clr) | rises;
      if (h && bus_wr && o == 2'd2) m_press = '0;
      else m_press = m_press + 16'($countones(rises));
      if (h && bus_wr && o == 2'd3) m_irqen = bus_wdata;
      m_level = nl;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      check("rdata", 32'(bus_rdata), 32'(m_rdata));
      check("bus_hit", 32'(bus_hit), 32'(m_hit));
      check("irq", 32'(irq), 32'(m_irq()));
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic rd_expect(input string tag, input logic [1:0] o, input logic [15:0] exp);
      bus_en = 1'b1; bus_wr = 1'b0; bus_addr = BASE + 14'(o);
      step();
      bus_en = 1'b0;
      check(tag, 32'(bus_rdata), {16'h0, exp});
   endtask

   task automatic store(input logic [1:0] o, input logic [15:0] d);
      bus_en = 1'b1; bus_wr = 1'b1; bus_addr = BASE + 14'(o); bus_wdata = d;
      step();
      bus_en = 1'b0; bus_wr = 1'b0;
   endtask

   task automatic do_reset();
      CLR = 1'b1;
      #1;
      model_reset();
      check("reset rdata", 32'(bus_rdata), 0);
      check("reset hit", 32'(bus_hit), 0);
      check("reset irq", 32'(irq), 0);
      idle(2);
      CLR = 1'b0;
   endtask

   initial begin
      logic [1:0] o;
      model_reset();
      idle(2);
      check("por rdata", 32'(bus_rdata), 0);
      check("por irq", 32'(irq), 0);
      CLR = 1'b0;

      // single press, exact LEVEL latency
      do_reset();
      btn_raw = 16'h0001;
      idle(5);
      rd_expect("t1 level early", 2'd0, 16'h0000);
      rd_expect("t1 level", 2'd0, 16'h0001);
      idle(3);
      btn_raw = '0;
      rd_expect("t1 event", 2'd1, 16'h0001);
      rd_expect("t1 press", 2'd2, 16'h0001);
      idle(8);

      // single-cycle bounces never register
      do_reset();
      btn_raw = 16'h0001; step();
      btn_raw = 16'h0000; step();
      btn_raw = 16'h0001; step();
      btn_raw = 16'h0000; idle(10);
      rd_expect("t2 level", 2'd0, 16'h0000);
      rd_expect("t2 event", 2'd1, 16'h0000);
      rd_expect("t2 press", 2'd2, 16'h0000);

      // simultaneous presses and W1C
      do_reset();
      btn_raw = 16'h000A; idle(8);
      rd_expect("t3 event", 2'd1, 16'h000A);
      rd_expect("t3 press", 2'd2, 16'h0002);
      store(2'd1, 16'h0002);
      rd_expect("t3 event w1c", 2'd1, 16'h0008);
      btn_raw = '0; idle(8);

      // irq assert and clear
      do_reset();
      store(2'd3, 16'h0004);
      btn_raw = 16'h0004; idle(7);
      check("t4 irq set", 32'(irq), 1);
      store(2'd1, 16'h0004);
      check("t4 irq clear", 32'(irq), 0);
      btn_raw = '0; idle(8);

      // collisions: press edge is the 6th clock after the pin rises
      do_reset();
      btn_raw = 16'h0001; idle(5);
      store(2'd1, 16'h0001);
      rd_expect("t5 event set wins", 2'd1, 16'h0001);
      btn_raw = '0; idle(8);
      btn_raw = 16'h0001; idle(5);
      store(2'd2, 16'h1234);
      rd_expect("t5 press store wins", 2'd2, 16'h0000);
      btn_raw = '0; idle(8);

      // press counter wrap
      do_reset();
      for (int k = 0; k < 4095; k++) begin
         btn_raw = 16'hFFFF; idle(5);
         btn_raw = 16'h0000; idle(5);
      end
      btn_raw = 16'h7FFF; idle(5);
      btn_raw = 16'h0000; idle(8);
      rd_expect("t5 press max", 2'd2, 16'hFFFF);
      btn_raw = 16'h0001; idle(5);
      btn_raw = 16'h0000; idle(8);
      rd_expect("t5 press wrap", 2'd2, 16'h0000);

      // address decode and mid-debounce reset
      do_reset();
      btn_raw = 16'h0002; idle(8);
      btn_raw = 16'h0000; idle(8);
      rd_expect("t6 event", 2'd1, 16'h0002);
      bus_en = 1'b1; bus_wr = 1'b0; bus_addr = BASE + 14'd4;
      step();
      bus_en = 1'b0;
      check("t6 miss hit", 32'(bus_hit), 0);
      check("t6 miss rdata", 32'(bus_rdata), 32'h0002);
      bus_en = 1'b1; bus_addr = BASE - 14'd1;
      step();
      bus_en = 1'b0;
      check("t6 below hit", 32'(bus_hit), 0);
      btn_raw = 16'h0001; idle(3);
      do_reset();
      btn_raw = 16'h0000; idle(10);
      rd_expect("t6 no event", 2'd1, 16'h0000);
      rd_expect("t6 no level", 2'd0, 16'h0000);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(3) == 0) btn_raw = N'($urandom);
         if ($urandom_range(2) == 0) begin
            o = 2'($urandom);
            bus_en = 1'b1;
            bus_wr = ($urandom_range(1) == 1) && (o != 2'd2 || $urandom_range(7) == 0);
            case ($urandom_range(3))
               0:       bus_addr = 14'($urandom);
               1:       bus_addr = BASE + 14'd4 + 14'(o);
               default: bus_addr = BASE + 14'(o);
            endcase
            bus_wdata = 16'($urandom);
         end
         if ($urandom_range(499) == 0) begin
            bus_en = 1'b0;
            do_reset();
         end else begin
            step();
         end
         bus_en = 1'b0;
         bus_wr = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
